// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous memory port between instruction fetch
//               and the load/store path. Round-robin arbitration on conflict,
//               fixed-latency access, store byte-lane steering and load
//               sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              ls_misalign,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [2:0] c_lat     = 3'(MEM_LATENCY);
  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;
  localparam logic [1:0] c_sz_bad  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_own_ls;    // current transaction belongs to the LSU
  logic              r_prio_ls;   // LSU wins the next conflict
  logic              r_we;
  logic              r_uns;
  logic              r_err;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cnt;

  logic              w_any_req;
  logic              w_conflict;
  logic              w_gnt_ls;
  logic              w_misalign;
  logic              w_capture;
  logic              w_store_issue;
  logic [3:0]        w_lane_we;
  logic [31:0]       w_lane_wdata;
  logic [15:0]       w_lane16;
  logic [31:0]       w_load_ext;
  logic              unused_addr_bits;

  assign w_any_req  = if_req | ls_req;
  assign w_conflict = if_req & ls_req;
  // Lone requester wins; on conflict the round-robin pointer decides.
  assign w_gnt_ls   = ls_req & (~if_req | r_prio_ls);
  assign w_misalign = (ls_size == c_sz_bad)
                    | ((ls_size == c_sz_half) & ls_addr[0])
                    | ((ls_size == c_sz_word) & (ls_addr[1:0] != 2'b00));
  // Last wait cycle: memory data is valid now.
  assign w_capture  = (r_state == S_WAIT) && (r_cnt <= 3'd1);

  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2], ls_addr[31:ADDR_W+2]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; rejected LSU accesses skip the memory cycle entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_ls && w_misalign) w_state_nxt = S_RESP;
        else if (w_any_req)         w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt <= 3'd1) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the granted request and advance the round-robin pointer on conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own_ls  <= 1'b0;
      r_prio_ls <= 1'b1;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_err     <= 1'b0;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      r_waddr   <= '0;
      r_wdata   <= 32'h0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_own_ls <= w_gnt_ls;
      if (w_conflict) r_prio_ls <= ~w_gnt_ls;
      r_we     <= w_gnt_ls & ls_we;
      r_uns    <= ls_unsigned;
      r_err    <= w_gnt_ls & w_misalign;
      r_size   <= ls_size;
      r_off    <= ls_addr[1:0];
      r_waddr  <= w_gnt_ls ? ls_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
      r_wdata  <= ls_wdata;
    end
  end

  // Latency counter: loaded during the issue cycle, counts down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cnt <= 3'd0;
    else if (r_state == S_ISSUE) r_cnt <= c_lat;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt - 3'd1;
  end

  // Store lane steering: replicate data, enable only the addressed bytes.
  always_comb begin
    w_lane_we    = 4'b1111;
    w_lane_wdata = r_wdata;
    case (r_size)
      c_sz_byte: begin
        w_lane_we    = 4'b0001 << r_off;
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      c_sz_half: begin
        w_lane_we    = r_off[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_we    = 4'b1111;
        w_lane_wdata = r_wdata;
      end
    endcase
  end

  // Load lane select followed by sign or zero extension.
  always_comb begin
    w_lane16   = 16'(mem_rdata >> {r_off, 3'b000});
    w_load_ext = mem_rdata;
    case (r_size)
      c_sz_byte: w_load_ext = r_uns ? {24'h0, w_lane16[7:0]} : {{24{w_lane16[7]}}, w_lane16[7:0]};
      c_sz_half: w_load_ext = r_uns ? {16'h0, w_lane16}      : {{16{w_lane16[15]}}, w_lane16};
      default:   w_load_ext = mem_rdata;
    endcase
  end

  // Response data registers; stores and rejected accesses leave ls_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= 32'h0;
      ls_rdata <= 32'h0;
    end else if (w_capture) begin
      if (!r_own_ls)  if_rdata <= mem_rdata;
      else if (!r_we) ls_rdata <= w_load_ext;
    end
  end

  // Memory strobes are driven only during the single issue cycle.
  assign w_store_issue = (r_state == S_ISSUE) & r_own_ls & r_we;
  assign mem_en        = (r_state == S_ISSUE);
  assign mem_addr      = mem_en ? r_waddr : '0;
  assign mem_we        = w_store_issue ? w_lane_we : 4'b0000;
  assign mem_wdata     = w_store_issue ? w_lane_wdata : 32'h0;

  assign busy          = (r_state != S_IDLE);
  assign if_ready      = (r_state == S_RESP) & ~r_own_ls;
  assign ls_ready      = (r_state == S_RESP) & r_own_ls;
  assign ls_misalign   = (r_state == S_RESP) & r_own_ls & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A latency-1 instance
//               runs directed and random transactions against a byte-level
//               memory model; a latency-3 instance covers timing and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic          rst, if_req, ls_req, ls_we, ls_unsigned;
  logic [31:0]   if_addr, ls_addr, ls_wdata;
  logic [1:0]    ls_size;
  logic          if_ready, ls_ready, ls_misalign, mem_en, busy;
  logic [31:0]   if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;

  // latency-3 instance (fetch side only)
  logic          b_rst, b_if_req;
  logic [31:0]   b_if_addr;
  logic          b_if_ready, b_ls_ready, b_ls_misalign, b_mem_en, b_busy;
  logic [31:0]   b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]    b_mem_we;
  logic [AW-1:0] b_mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LATENCY(LAT1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .ls_misalign(ls_misalign), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .MEM_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .ls_req(1'b0), .ls_we(1'b0), .ls_size(2'b00), .ls_unsigned(1'b0),
    .ls_addr(32'h0), .ls_wdata(32'h0), .ls_ready(b_ls_ready), .ls_rdata(b_ls_rdata),
    .ls_misalign(b_ls_misalign), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memories seen by the DUTs, and the reference image the model maintains.
  logic [31:0] mem1    [0:1023];
  logic [31:0] mem3    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd1, s0, s1, s2;

  assign mem_rdata   = rd1;
  assign b_mem_rdata = s2;

  // Synchronous memory with one-cycle read, byte-write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      rd1 <= mem1[mem_addr];
      if (mem_we[0]) mem1[mem_addr][7:0]   <= mem_wdata[7:0];
      if (mem_we[1]) mem1[mem_addr][15:8]  <= mem_wdata[15:8];
      if (mem_we[2]) mem1[mem_addr][23:16] <= mem_wdata[23:16];
      if (mem_we[3]) mem1[mem_addr][31:24] <= mem_wdata[31:24];
    end
  end

  // Read-only memory with a three-cycle read pipeline.
  always @(posedge clk) begin
    if (b_mem_en) s0 <= mem3[b_mem_addr];
    s1 <= s0;
    s2 <= s1;
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  bit          m_prio_ls = 1'b1;     // model: LSU wins the next conflict
  logic [31:0] m_ls_rdata = 32'h0;   // model: last load result

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration round: optional fetch and optional LSU request presented together.
  task automatic run_txn(input bit do_if, input logic [31:0] ia, input bit do_ls,
                         input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    bit          mis, ls_first, done;
    int          off, nbytes, t_if, t_ls, d_ls, c, got_if, got_ls;
    logic [3:0]  ewe;
    logic [31:0] ewd, sh;
    mis    = do_ls && ((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    off    = int'(a[1:0]);
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ewe    = 4'b0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + nbytes) ewe[b] = 1'b1;
    ewd    = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
    d_ls   = mis ? 1 : 2 + LAT1;
    ls_first = do_ls && (!do_if || m_prio_ls);
    if (do_if && do_ls) m_prio_ls = !ls_first;
    t_if = 0; t_ls = 0;
    if (ls_first) begin
      t_ls = d_ls;
      if (do_if) t_if = t_ls + 1 + (2 + LAT1);
    end else begin
      if (do_if) t_if = 2 + LAT1;
      if (do_ls) t_ls = (do_if ? t_if + 1 : 0) + d_ls;
    end
    if_req = do_if; if_addr = ia;
    ls_req = do_ls; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = a; ls_wdata = wd;
    c = 0; got_if = 0; got_ls = 0; done = 1'b0;
    while (!done && c < 24) begin
      @(posedge clk); #1; c++;
      if (got_if != 0) if_req = 1'b0;
      if (got_ls != 0) ls_req = 1'b0;
      if (mem_en) begin
        if (do_if && c == t_if - 2) begin
          chk("if_mem_addr", 32'(mem_addr), 32'(ia[11:2]));
          chk("if_mem_we", 32'(mem_we), 32'h0);
        end else if (do_ls && !mis && c == t_ls - 2) begin
          chk("ls_mem_addr", 32'(mem_addr), 32'(a[11:2]));
          chk("ls_mem_we", 32'(mem_we), we ? 32'(ewe) : 32'h0);
          if (we) chk("ls_mem_wdata", mem_wdata, ewd);
        end else chk("stray_mem_en", 32'(mem_en), 32'h0);
      end
      if (if_ready) begin
        if (do_if && got_if == 0) begin
          got_if = c;
          chk("if_ready_cycle", c, t_if);
          chk("if_rdata", if_rdata, ref_mem[ia[11:2]]);
        end else chk("stray_if_ready", 32'(if_ready), 32'h0);
      end
      if (ls_ready) begin
        if (do_ls && got_ls == 0) begin
          got_ls = c;
          chk("ls_ready_cycle", c, t_ls);
          chk("ls_misalign", 32'(ls_misalign), 32'(mis));
          if (!mis && we) begin
            for (int b = off; b < off + nbytes; b++)
              ref_mem[a[11:2]][8*b +: 8] = wd[8*(b-off) +: 8];
          end else if (!mis) begin
            sh = ref_mem[a[11:2]] >> (8 * off);
            if (nbytes == 1)      m_ls_rdata = uns ? (sh & 32'hFF)   : 32'($signed(sh[7:0]));
            else if (nbytes == 2) m_ls_rdata = uns ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
            else                  m_ls_rdata = sh;
          end
          chk("ls_rdata", ls_rdata, m_ls_rdata);
        end else chk("stray_ls_ready", 32'(ls_ready), 32'h0);
      end else if (ls_misalign) chk("misalign_without_ready", 32'(ls_misalign), 32'h0);
      done = (!do_if || got_if != 0) && (!do_ls || got_ls != 0);
    end
    chk("txn_completed", 32'(done), 32'h1);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    chk("idle_after_txn", 32'(busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, got, nready, nbad, kind;
    logic [31:0] seen;
    rst = 1'b1; b_rst = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0; ls_unsigned = 0;
    ls_addr = 0; ls_wdata = 0; b_if_req = 0; b_if_addr = 0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = $urandom; ref_mem[i] = mem1[i]; mem3[i] = 32'h0;
    end

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ready", {30'h0, if_ready, ls_ready}, 0);
    chk("rst_misalign", 32'(ls_misalign), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    // single fetch
    mem1[10'h10] = 32'h00A00093; ref_mem[10'h10] = 32'h00A00093;
    run_txn(1, 32'h40, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("fetch_lit", if_rdata, 32'h00A00093);

    // conflicts: first to LSU, second to fetch
    mem1[10'h40] = 32'h80FF1234; ref_mem[10'h40] = 32'h80FF1234;
    run_txn(1, 32'h44, 1, 0, 2'b10, 0, 32'h100, 32'h0);
    chk("lw_lit", ls_rdata, 32'h80FF1234);
    run_txn(1, 32'h48, 1, 0, 2'b10, 0, 32'h104, 32'h0);

    // store byte lane
    run_txn(0, 0, 1, 1, 2'b00, 0, 32'h103, 32'h000000AB);
    chk("sb_mem_lit", mem1[10'h40], 32'hABFF1234);
    mem1[10'h40] = 32'h80FF1234; ref_mem[10'h40] = 32'h80FF1234;

    // load extension
    run_txn(0, 0, 1, 0, 2'b01, 0, 32'h102, 32'h0);
    chk("lh_lit", ls_rdata, 32'hFFFF80FF);
    run_txn(0, 0, 1, 0, 2'b01, 1, 32'h102, 32'h0);
    chk("lhu_lit", ls_rdata, 32'h000080FF);
    run_txn(0, 0, 1, 0, 2'b00, 0, 32'h100, 32'h0);
    chk("lb_lit", ls_rdata, 32'h00000034);

    // rejected accesses
    run_txn(0, 0, 1, 0, 2'b10, 0, 32'h102, 32'h0);
    run_txn(0, 0, 1, 1, 2'b11, 0, 32'h100, 32'hFFFFFFFF);
    chk("misalign_keeps_rdata", ls_rdata, 32'h00000034);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, $urandom, kind != 0, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem1[i] !== ref_mem[i]) nbad++;
    chk("mem_image", nbad, 0);

    // latency 3: normal fetch
    mem3[10'h20] = 32'hDEADBEEF; b_if_addr = 32'h80; b_if_req = 1'b1;
    c = 0; got = 0; seen = 32'h0;
    while (got == 0 && c < 12) begin
      @(posedge clk); #1; c++;
      if (c == 1) chk("l3_mem_en", 32'(b_mem_en), 1);
      else if (b_mem_en) chk("l3_stray_mem_en", 32'(b_mem_en), 0);
      if (b_if_ready) begin got = c; seen = b_if_rdata; end
    end
    chk("l3_ready_cycle", got, 5);
    chk("l3_rdata", seen, 32'hDEADBEEF);
    @(posedge clk); #1; b_if_req = 1'b0;

    // latency 3: reset during wait abandons the fetch
    mem3[10'h21] = 32'h12345678; b_if_addr = 32'h84; b_if_req = 1'b1;
    @(posedge clk); #1;
    chk("l3b_mem_en", 32'(b_mem_en), 1);
    @(posedge clk); #1;
    chk("l3b_busy_before_rst", 32'(b_busy), 1);
    #2 b_rst = 1'b1;
    #1;
    chk("l3b_rst_busy", 32'(b_busy), 0);
    chk("l3b_rst_mem_en", 32'(b_mem_en), 0);
    chk("l3b_rst_if_rdata", b_if_rdata, 0);
    b_if_req = 1'b0;
    nready = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_rst = 1'b0;
      if (b_if_ready) nready++;
    end
    chk("l3b_no_ready", nready, 0);
    chk("l3b_idle", 32'(b_busy), 0);

    // latency 3: request after reset completes normally
    b_if_req = 1'b1;
    c = 0; got = 0; seen = 32'h0;
    while (got == 0 && c < 12) begin
      @(posedge clk); #1; c++;
      if (b_if_ready) begin got = c; seen = b_if_rdata; end
    end
    chk("l3c_ready_cycle", got, 5);
    chk("l3c_rdata", seen, 32'h12345678);
    @(posedge clk); #1; b_if_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
